// File: rtl/xor_descrambler.sv
// Self-synchronizing serial descrambler for the x^LEN + x^TAP_B + 1 XOR
// scrambler. One scrambled bit enters per accepted transfer; the original
// data bit is recovered by XOR-ing it with two delayed copies of the raw
// received stream. A single output register sits between a valid/ready
// input port and a valid/ready output port.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both 1. A valid source holds its data stable
// until that edge, and ready may depend combinationally on downstream ready
// (in_ready = ~out_valid | out_ready), so the block runs at 1 bit/cycle
// while still honouring backpressure with no extra buffering.

module xor_descrambler #(
  parameter int LEN   = 7,
  parameter int TAP_A = 7,
  parameter int TAP_B = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        bypass,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        locked,
  output logic [15:0] bit_count,
  output logic [0:0]  dbg_state
);

  // Fill counter spans 0..LEN inclusive.
  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(LEN);
  localparam logic [FW-1:0] FILL_LAST = FW'(LEN - 1);

  // Lock FSM encoding.
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Reject parameter sets that do not describe a valid two-tap scrambler.
  if (LEN < 3 || LEN > 16) begin : g_bad_len
    $error("xor_descrambler: LEN must be in 3..16");
  end
  if (TAP_A != LEN) begin : g_bad_tap_a
    $error("xor_descrambler: TAP_A must equal LEN");
  end
  if (TAP_B < 1 || TAP_B >= TAP_A) begin : g_bad_tap_b
    $error("xor_descrambler: TAP_B must satisfy 1 <= TAP_B < TAP_A");
  end

  // Registered state and its next-state values.
  logic [LEN-1:0] hist_q,      hist_d;
  logic [FW-1:0]  fill_q,      fill_d;
  logic [0:0]     state_q,     state_d;
  logic           out_bit_q,   out_bit_d;
  logic           out_valid_q, out_valid_d;
  logic           out_lock_q,  out_lock_d;
  logic [15:0]    count_q,     count_d;

  logic accept;
  logic xfer;
  logic descr_bit;

  // Handshake qualifiers; in_ready opens whenever the output register is
  // empty or is being drained on this same edge.
  always_comb begin
    in_ready = ~out_valid_q | out_ready;
    accept   = in_valid & in_ready;
    xfer     = out_valid_q & out_ready;
  end

  // Descrambled bit: the history holds raw line bits, so the taps see
  // exactly what the remote scrambler fed back, which makes the block
  // self-synchronizing after LEN bits.
  always_comb begin
    descr_bit = in_bit ^ hist_q[TAP_A-1] ^ hist_q[TAP_B-1];
  end

  // Next-state logic. clr outranks every handshake: a concurrent accept is
  // dropped and a concurrent output transfer simply completes.
  always_comb begin
    hist_d      = hist_q;
    fill_d      = fill_q;
    state_d     = state_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    out_lock_d  = out_lock_q;
    count_d     = count_q;

    if (clr) begin
      hist_d      = '0;
      fill_d      = '0;
      state_d     = ST_FILL;
      out_bit_d   = 1'b0;
      out_valid_d = 1'b0;
      out_lock_d  = 1'b0;
      count_d     = '0;
    end else if (accept) begin
      // bypass only selects the output value; history always records the
      // raw line bit so descrambling resumes cleanly when bypass drops.
      out_bit_d   = bypass ? in_bit : descr_bit;
      out_valid_d = 1'b1;
      // The bit is trustworthy only if the history was already full before
      // this bit arrived, which is exactly the LOCK state.
      out_lock_d  = (state_q == ST_LOCK);
      hist_d      = {hist_q[LEN-2:0], in_bit};
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FW'(1);
      end
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
      // FILL -> LOCK when this accept completes the history. There is no
      // path back to FILL except clr or reset.
      if (state_q == ST_FILL && fill_q == FILL_LAST) begin
        state_d = ST_LOCK;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q      <= '0;
      fill_q      <= '0;
      state_q     <= ST_FILL;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_lock_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_lock_q  <= out_lock_d;
      count_q     <= count_d;
    end
  end

  // Output drive from registered state.
  always_comb begin
    out_bit   = out_bit_q;
    out_valid = out_valid_q;
    locked    = out_lock_q;
    bit_count = count_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed testbench for xor_descrambler (LEN=7, TAP_A=7, TAP_B=4).
module tb_xor_descrambler;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        bypass;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic [15:0] bit_count;
  logic [0:0]  dbg_state;

  int tests_run;
  int tests_failed;

  logic src_bits [256];
  logic scr_bits [256];
  logic nostall  [256];
  logic stalled  [256];

  xor_descrambler #(.LEN(7), .TAP_A(7), .TAP_B(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bypass    (bypass),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .bit_count (bit_count),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    clr       = 1'b0;
    bypass    = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Source PRBS and reference scrambler x^7+x^4+1 seeded with 7'h5A.
  task automatic build_stream();
    logic [6:0] st;
    logic       s;
    st = 7'h5A;
    for (int i = 0; i < 256; i++) begin
      src_bits[i] = 1'($urandom_range(0, 1));
      s = src_bits[i] ^ st[6] ^ st[3];
      scr_bits[i] = s;
      st = {st[5:0], s};
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_bit !== 1'b0) begin tests_failed++; $display("FAIL reset_out_bit got %b want 0", out_bit); end
    tests_run++;
    if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked got %b want 0", locked); end
    tests_run++;
    if (bit_count !== 16'd0) begin tests_failed++; $display("FAIL reset_bit_count got %0d want 0", bit_count); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++;
    if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL reset_state got %b want 0", dbg_state); end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_zeros();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b0;
      step();
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL zeros_valid[%0d] got %b want 1", i, out_valid); end
      tests_run++;
      if (out_bit !== 1'b0) begin tests_failed++; $display("FAIL zeros_bit[%0d] got %b want 0", i, out_bit); end
      tests_run++;
      if (locked !== (i >= 7)) begin tests_failed++; $display("FAIL zeros_locked[%0d] got %b want %b", i, locked, (i >= 7)); end
    end
    in_valid = 1'b0;
    tests_run++;
    if (bit_count !== 16'd20) begin tests_failed++; $display("FAIL zeros_count got %0d want 20", bit_count); end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL zeros_drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_impulse();
    logic exp;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_bit   = (i == 0);
      step();
      exp = (i == 0) || (i == 4) || (i == 7);
      tests_run++;
      if (out_bit !== exp) begin tests_failed++; $display("FAIL impulse_bit[%0d] got %b want %b", i, out_bit, exp); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_round_trip();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_bit   = scr_bits[i];
      step();
      nostall[i] = out_bit;
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rt_valid[%0d] got %b want 1", i, out_valid); end
      if (i >= 7) begin
        tests_run++;
        if (out_bit !== src_bits[i]) begin tests_failed++; $display("FAIL rt_bit[%0d] got %b want %b", i, out_bit, src_bits[i]); end
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (bit_count !== 16'd256) begin tests_failed++; $display("FAIL rt_count got %0d want 256", bit_count); end
    step();
  endtask

  task automatic test_backpressure();
    logic mv;
    logic exp_rdy;
    logic acc;
    int   idx;
    int   got;
    int   cyc;
    do_reset();
    mv  = 1'b0;
    idx = 0;
    got = 0;
    cyc = 0;
    while (got < 256 && cyc < 3000) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (idx < 256);
      in_bit    = (idx < 256) ? scr_bits[idx] : 1'b0;
      #1;
      exp_rdy = ~mv | out_ready;
      tests_run++;
      if (in_ready !== exp_rdy) begin tests_failed++; $display("FAIL bp_in_ready[cyc %0d] got %b want %b", cyc, in_ready, exp_rdy); end
      if (mv && out_ready) begin
        stalled[got] = out_bit;
        got++;
      end
      acc = in_valid && exp_rdy;
      if (acc) idx++;
      mv = acc ? 1'b1 : ((mv && out_ready) ? 1'b0 : mv);
      step();
      tests_run++;
      if (out_valid !== mv) begin tests_failed++; $display("FAIL bp_out_valid[cyc %0d] got %b want %b", cyc, out_valid, mv); end
      cyc++;
    end
    tests_run++;
    if (got != 256) begin tests_failed++; $display("FAIL bp_complete got %0d outputs want 256", got); end
    for (int i = 0; i < got; i++) begin
      tests_run++;
      if (stalled[i] !== nostall[i]) begin tests_failed++; $display("FAIL bp_bit[%0d] got %b want %b", i, stalled[i], nostall[i]); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_clr();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_bit   = scr_bits[i];
      step();
    end
    tests_run++;
    if (dbg_state !== 1'b1) begin tests_failed++; $display("FAIL clr_pre_state got %b want 1", dbg_state); end
    tests_run++;
    if (bit_count !== 16'd50) begin tests_failed++; $display("FAIL clr_pre_count got %0d want 50", bit_count); end
    // clr together with a valid input bit: the bit must be discarded.
    clr      = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (locked !== 1'b0) begin tests_failed++; $display("FAIL clr_locked got %b want 0", locked); end
    tests_run++;
    if (bit_count !== 16'd0) begin tests_failed++; $display("FAIL clr_count got %0d want 0", bit_count); end
    tests_run++;
    if (dbg_state !== 1'b0) begin tests_failed++; $display("FAIL clr_state got %b want 0", dbg_state); end
    // Zeros after clr: a retained in-flight 1 would surface at indices 3 and 6.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b0;
      step();
      tests_run++;
      if (out_bit !== 1'b0) begin tests_failed++; $display("FAIL clr_post_bit[%0d] got %b want 0", i, out_bit); end
      tests_run++;
      if (locked !== (i == 7)) begin tests_failed++; $display("FAIL clr_relock[%0d] got %b want %b", i, locked, (i == 7)); end
    end
    in_valid = 1'b0;
    tests_run++;
    if (bit_count !== 16'd8) begin tests_failed++; $display("FAIL clr_post_count got %0d want 8", bit_count); end
    tests_run++;
    if (dbg_state !== 1'b1) begin tests_failed++; $display("FAIL clr_post_state got %b want 1", dbg_state); end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    step();
    in_bit = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid got %b want 1", out_valid); end
    tests_run++;
    if (out_bit !== 1'b1) begin tests_failed++; $display("FAIL stall_bit got %b want 1", out_bit); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    step();
    tests_run++;
    if (out_bit !== 1'b1 || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL stall_hold got bit=%b valid=%b want bit=1 valid=1", out_bit, out_valid);
    end
    tests_run++;
    if (bit_count !== 16'd1) begin tests_failed++; $display("FAIL stall_count got %0d want 1", bit_count); end
    // Assert reset between clock edges; outputs must clear immediately.
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_bit !== 1'b0) begin tests_failed++; $display("FAIL areset_bit got %b want 0", out_bit); end
    tests_run++;
    if (bit_count !== 16'd0) begin tests_failed++; $display("FAIL areset_count got %0d want 0", bit_count); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL areset_in_ready got %b want 1", in_ready); end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    logic [4:0] pat;
    logic [2:0] exp_after;
    out_ready = 1'b1;
    bypass    = 1'b1;
    pat       = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = pat[4-i];
      step();
      tests_run++;
      if (out_bit !== pat[4-i]) begin tests_failed++; $display("FAIL bypass_bit[%0d] got %b want %b", i, out_bit, pat[4-i]); end
    end
    // Back to descrambling: history must hold the raw 1,0,1,0,1 stream.
    bypass    = 1'b0;
    exp_after = 3'b011;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b0;
      step();
      tests_run++;
      if (out_bit !== exp_after[2-i]) begin tests_failed++; $display("FAIL bypass_hist[%0d] got %b want %b", i, out_bit, exp_after[2-i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clr          = 1'b0;
    bypass       = 1'b0;
    in_bit       = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    build_stream();
    test_reset();
    test_zeros();
    test_impulse();
    test_round_trip();
    test_backpressure();
    test_clr();
    test_async_reset();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/xor_descrambler.md
Name: xor_descrambler

Overview:
- Self-synchronizing serial descrambler. It is the receive-side counterpart of the team's XOR-based scrambler, with polynomial x^LEN + x^TAP_B + 1.
- It takes one scrambled bit per accepted transfer and recovers the original data bit by XOR-ing it with two delayed copies of the received stream.
- It sits between the serial line front end and the bit-level deframer, with valid/ready handshakes on both sides.

Parameters:
- LEN, 7, scrambler polynomial order (history register length); legal range 3..16.
- TAP_A, 7, first tap position (1-based delay); must equal LEN.
- TAP_B, 4, second tap position (1-based delay); 1 <= TAP_B < TAP_A.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of history, lock and output stage; priority over all handshakes.
- bypass  input  1  when 1, the output bit equals the input bit; history still updates.
- in_bit  input  1  scrambled input bit.
- in_valid  input  1  in_bit valid.
- in_ready  output  1  block can accept in_bit this cycle.
- out_bit  output  1  descrambled bit.
- out_valid  output  1  out_bit valid.
- out_ready  input  1  downstream accepts out_bit.
- locked  output  1  history fully populated; out_bit is trustworthy.
- bit_count  output  16  accepted-input counter, saturating at 16'hFFFF.

Behaviour:
- State:
  - history S[LEN-1:0], where S[0] is the most recently received scrambled bit.
  - fill counter F, range 0..LEN.
  - output register (out_bit, out_valid, out_locked).
- Reset (rst_n=0, async):
  - S=0, F=0, bit_count=0.
  - out_bit=0, out_valid=0, locked=0.
  - in_ready=1 is combinational from out_valid=0.
- Handshakes:
  - in_ready = ~out_valid | out_ready (combinational).
  - Input accept when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- On input accept, at the next edge:
  - out_bit <= bypass ? in_bit : in_bit ^ S[TAP_A-1] ^ S[TAP_B-1].
  - out_valid <= 1.
  - S <= {S[LEN-2:0], in_bit}. The history always holds raw scrambled bits, never descrambled ones, regardless of bypass.
  - F <= min(F+1, LEN).
  - bit_count <= saturating increment.
- Output transfer without a new accept: out_valid <= 0.
- Simultaneous output transfer and input accept: the register reloads and out_valid stays 1. Full throughput is 1 bit/cycle.
- Stall (out_valid=1, out_ready=0): in_ready=0. out_bit, out_valid and locked hold stable. S and F are unchanged.
- Latency: 1 cycle from input accept to out_valid.
- locked:
  - Registered alongside out_bit.
  - Equals 1 for the output bit produced when F (before increment) == LEN, i.e. from the (LEN+1)-th accepted bit onward.
  - The first LEN outputs after reset or clr carry locked=0.
- Lock FSM, two states:
  - FILL (F<LEN) -> LOCK when F reaches LEN on an accept.
  - LOCK -> FILL only on clr or reset. There is no loss-of-lock detection in this block.
- clr=1 at an edge:
  - S=0, F=0, out_valid=0, locked=0, bit_count=0.
  - A concurrent input accept is discarded.
  - A concurrent output transfer is treated as completed.
- bypass changes take effect on the next accepted bit. There is no pipeline flush.
- bit_count never wraps; it holds 16'hFFFF.

Test Plan:
- Reset then 20 accepted zeros with out_ready=1 -> out_bit=0 for all 20. out_valid high from cycle 1 through 20. locked=0 for outputs 1-7 and 1 for outputs 8-20. bit_count=20.
- Impulse: after reset, feed 1 then 15 zeros -> out_bit=1 at output indices 0, 4 and 7, and 0 at all other indices.
- Round trip: a reference scrambler (x^7+x^4+1, seed 7'h5A) scrambles 256 PRBS bits into the DUT -> outputs 7..255 match the source bits exactly.
- Backpressure: out_ready toggles 1,0,0,1 repeating during the round-trip stream -> in_ready=0 whenever out_valid&~out_ready. No bit lost or duplicated; output sequence identical to the unstalled run.
- Mid-stream clr after 50 bits, followed by a clr with in_valid=1 the same cycle -> out_valid=0 next cycle and the in-flight bit is dropped. locked=0 and bit_count=0. Relock after 7 accepts.
- Async reset asserted mid-stall (out_valid=1, out_ready=0) -> all outputs reach their reset values without a clock edge. bypass=1 stream of 10101 -> out_bit follows in_bit exactly.
